// File: rtl/i2s_stereo_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_stereo_rx
// Description : I2S stereo receiver with mid-frame strobe and stall detection.
//               Define I2S_RX_ERRCNT_EN to enable the saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_stereo_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    bclk,
    input  logic                    lrclk,
    input  logic                    sdata,
    output logic signed [WIDTH-1:0] out_l,
    output logic signed [WIDTH-1:0] out_r,
    output logic                    out_valid,
    output logic                    out_valid_180,
    output logic                    frame_err,
    output logic [15:0]             err_count
);

    localparam logic [5:0]  c_width    = 6'(WIDTH);
    localparam logic [5:0]  c_width_m1 = 6'(WIDTH - 1);
    localparam logic [5:0]  c_bits_max = 6'd63;
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    // {bclk, lrclk, sdata} per stage; oldest stage in the top three bits
    logic [SYNC_STAGES*3-1:0] r_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (reset) r_sync <= '0;
                else       r_sync <= {bclk, lrclk, sdata};
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (reset) r_sync <= '0;
                else       r_sync <= {r_sync[SYNC_STAGES*3-4:0], bclk, lrclk, sdata};
            end
        end
    endgenerate

    logic w_bclk_s, w_lrclk_s, w_sdata_s;
    assign {w_bclk_s, w_lrclk_s, w_sdata_s} = r_sync[SYNC_STAGES*3-1 -: 3];

    state_t           r_state;
    logic             r_bclk_prev;
    logic             r_lr_prev;
    logic [WIDTH-1:0] r_shift;
    logic [5:0]       r_bits;
    logic [WIDTH-1:0] r_left;
    logic             r_left_ok;
    logic [15:0]      r_cnt;
    logic [15:0]      r_period;
    logic             r_period_valid;
    logic             r_pair_seen;

    logic             w_rise;
    logic             w_chan_end;
    logic             w_chan_ok;
    logic [WIDTH-1:0] w_word;
    logic             w_stall;
    logic             w_emit;
    logic             w_short;
    logic             w_mid;
    logic [15:0]      w_cnt_inc;
    logic [15:0]      w_half;

    assign w_rise     = w_bclk_s & ~r_bclk_prev;
    assign w_chan_end = w_rise && (((r_state == S_LEFT)  &&  w_lrclk_s) ||
                                   ((r_state == S_RIGHT) && !w_lrclk_s));
    // The bit at an lrclk-change rise is the one-bit-delayed LSB of the word
    // that is ending; it closes that word and never enters the new channel.
    assign w_chan_ok  = (r_bits >= c_width_m1);
    assign w_word     = (r_bits < c_width) ? {r_shift[WIDTH-2:0], w_sdata_s} : r_shift;
    assign w_stall    = enable && (r_state != S_IDLE) && (r_cnt == c_cnt_max);
    assign w_emit     = enable && !w_stall && w_chan_end && (r_state == S_RIGHT) &&
                        w_chan_ok && r_left_ok;
    assign w_short    = enable && !w_stall && w_chan_end && !w_chan_ok;
    assign w_cnt_inc  = r_cnt + 16'd1;
    assign w_half     = r_period >> 1;
    assign w_mid      = enable && r_period_valid && (r_state != S_IDLE) &&
                        (w_half != 16'd0) && (w_cnt_inc == w_half) && !w_emit && !w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_bclk_prev    <= 1'b0;
            r_lr_prev      <= 1'b0;
            r_shift        <= '0;
            r_bits         <= '0;
            r_left         <= '0;
            r_left_ok      <= 1'b0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_pair_seen    <= 1'b0;
            out_l          <= '0;
            out_r          <= '0;
            out_valid      <= 1'b0;
            out_valid_180  <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            r_bclk_prev   <= w_bclk_s;
            out_valid     <= w_emit;
            out_valid_180 <= w_mid;
            frame_err     <= w_short | w_stall;
            if (w_rise) r_lr_prev <= w_lrclk_s;

            if (!enable || w_stall) begin
                r_state        <= S_IDLE;
                r_cnt          <= '0;
                r_period_valid <= 1'b0;
                r_pair_seen    <= 1'b0;
                r_left_ok      <= 1'b0;
            end else begin
                if (r_state != S_IDLE) r_cnt <= w_cnt_inc;

                if (w_emit) begin
                    r_cnt       <= '0;
                    out_l       <= r_left;
                    out_r       <= w_word;
                    r_pair_seen <= 1'b1;
                    if (r_pair_seen) begin
                        r_period       <= w_cnt_inc;
                        r_period_valid <= 1'b1;
                    end
                end

                // A broken frame means the next pair is not a consecutive one
                if (w_short) begin
                    r_pair_seen    <= 1'b0;
                    r_period_valid <= 1'b0;
                end

                if (w_rise) begin
                    case (r_state)
                        S_IDLE: begin
                            if (r_lr_prev && !w_lrclk_s) begin
                                r_state   <= S_LEFT;
                                r_bits    <= '0;
                                r_shift   <= '0;
                                r_left_ok <= 1'b0;
                            end
                        end
                        S_LEFT: begin
                            if (w_lrclk_s) begin
                                r_state   <= S_RIGHT;
                                r_left    <= w_word;
                                r_left_ok <= w_chan_ok;
                                r_bits    <= '0;
                                r_shift   <= '0;
                            end else begin
                                if (r_bits < c_width) r_shift <= {r_shift[WIDTH-2:0], w_sdata_s};
                                if (r_bits != c_bits_max) r_bits <= r_bits + 6'd1;
                            end
                        end
                        S_RIGHT: begin
                            if (!w_lrclk_s) begin
                                r_state   <= S_LEFT;
                                r_left_ok <= 1'b0;
                                r_bits    <= '0;
                                r_shift   <= '0;
                            end else begin
                                if (r_bits < c_width) r_shift <= {r_shift[WIDTH-2:0], w_sdata_s};
                                if (r_bits != c_bits_max) r_bits <= r_bits + 6'd1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef I2S_RX_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if ((w_short || w_stall) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/i2s_stereo_rx.md
I2S_STEREO_RX -- requirements
Module: i2s_stereo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width, in bits, of out_l and out_r.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; synchronous and active-high reset.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: receive enable.
REQ-006 SHALL have ports bclk, lrclk and sdata, inputs, 1 bit each: asynchronous I2S lines from the external ADC.
REQ-007 SHALL have ports out_l and out_r, outputs, WIDTH bits, signed: left and right samples.
REQ-008 SHALL have port out_valid, output, 1 bit: one-cycle strobe marking a new L/R pair.
REQ-009 SHALL have port out_valid_180, output, 1 bit: one-cycle strobe at mid-frame, for the mid-frame strobe input of the stereo MPX stage.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle error strobe.
REQ-011 SHALL have port err_count, output, 16 bits: error count.

Function
REQ-012 SHALL pass bclk, lrclk and sdata through SYNC_STAGES-deep synchronizers; a bclk "rise" is synced bclk 0->1 between consecutive clk cycles; clk >= 4x bclk is required.
REQ-013 SHALL, on each rise, sample synced lrclk and sdata; lrclk low = left, high = right; standard I2S with one-bit delay.
REQ-014 SHALL implement states IDLE, LEFT, RIGHT; IDLE->LEFT on the first rise where lrclk goes 1->0; LEFT->RIGHT on lrclk 0->1; RIGHT->LEFT on lrclk 1->0.
REQ-015 SHALL ignore the bit sampled at the rise that detects an lrclk change (delay slot); subsequent bits shift MSB-first, the first WIDTH are kept, extras are ignored, and the bit counter saturates at 63.
REQ-016 SHALL, on a channel end with fewer than WIDTH bits captured, pulse frame_err and emit no pair for that frame; the next complete frame is emitted normally.
REQ-017 SHALL, on RIGHT->LEFT with both channels complete, update out_l/out_r and pulse out_valid in the clk cycle after the detected rise; outputs hold between strobes.
REQ-018 SHALL run a 16-bit period counter cleared on each out_valid; the value at out_valid is latched as period and is valid only after two consecutive pairs.
REQ-019 SHALL pulse out_valid_180 for one cycle when the counter equals period>>1, once per frame, only while period is valid.
REQ-020 SHALL, when the counter reaches 0xFFFF, pulse frame_err once, enter IDLE and invalidate period.
REQ-021 SHALL never assert out_valid and out_valid_180 in the same cycle; if period>>1 is 0, out_valid_180 is suppressed.
REQ-022 SHALL, on enable=0, enter IDLE next cycle, suppress all strobes, invalidate period and hold out_l/out_r.
REQ-023 SHALL make the first frame after IDLE produce no out_valid unless both LEFT and RIGHT are fully captured after entry.

Reset
REQ-024 SHALL, on reset, force out_l=0, out_r=0, out_valid=0, out_valid_180=0, frame_err=0, err_count=0, state IDLE, counters 0, period invalid and synchronizers 0.
REQ-025 SHALL give reset priority over enable and over an in-flight frame; a partial word is discarded without frame_err.

Configuration
REQ-026 SHALL gate the error counter with macro I2S_RX_ERRCNT_EN.
REQ-027 SHALL, with I2S_RX_ERRCNT_EN defined, increment err_count on each frame_err, saturating at 0xFFFF.
REQ-028 SHALL, without I2S_RX_ERRCNT_EN, tie err_count to constant 0 while the port remains present.

Verification
REQ-029 SHALL verify a normal frame: clk = 8x bclk, 32 bclk/frame, L=16'h8001, R=16'h7FFE -> out_l=-32767, out_r=32766, out_valid 1 cycle after the RIGHT->LEFT rise.
REQ-030 SHALL verify mid-frame timing: 3 frames at 256 clk/frame -> out_valid_180 exactly 128 clk after the 2nd and 3rd out_valid, none after the 1st.
REQ-031 SHALL verify a short channel: a left channel with 10 bclk -> one frame_err pulse, no out_valid that frame, err_count=1 (macro on) or 0 (macro off).
REQ-032 SHALL verify long words: 24 bits/channel with 16'h1234 in the top bits -> out_l=16'h1234, with no frame_err.
REQ-033 SHALL verify stall recovery: bclk stopped >65535 clk -> one frame_err, IDLE; after restart, first out_valid occurs after one complete L+R.
REQ-034 SHALL verify mid-frame reset: reset asserted mid-RIGHT -> all outputs 0 next cycle, no strobes until a full frame completes after release.
